fp4_accumulator: RTL and testbench

- Downstream stage of the FP4 multiplier: consumes the stream of FP4 (E2M1) products and accumulates VEC_LEN of them into a signed fixed-point dot-product sum.
- Each product is decoded to signed fixed point with 1 fractional bit (units of 0.5), then added with saturation.
- A completed sum is presented on a valid/ready output register, so a downstream writer can back-pressure the MAC.

---
 rtl/fp4_pkg.sv | 35 +++
 rtl/fp4_to_fixed.sv | 20 ++
 rtl/fp4_accumulator.sv | 111 +++++++++++
 tb/tb_fp4_accumulator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp4_pkg.sv
// Shared FP4 (E2M1) definitions: field layout, payload struct and magnitude decode.
package fp4_pkg;

    localparam int unsigned FP4_W        = 4;
    localparam int unsigned FP4_SIGN_BIT = 3;
    localparam int unsigned FP4_EXP_MSB  = 2;
    localparam int unsigned FP4_EXP_LSB  = 1;
    localparam int unsigned FP4_MAN_BIT  = 0;
    localparam int unsigned FP4_MAX_HALF = 12;
    localparam int unsigned FP4_MAG_W    = $clog2(FP4_MAX_HALF + 1);

    typedef struct packed {
        logic       sign;
        logic [1:0] exp;
        logic       man;
    } fp4_t;

    // Unsigned magnitude of an FP4 value in units of 0.5.
    function automatic logic [FP4_MAG_W-1:0] fp4_to_half_mag(input logic [FP4_W-1:0] raw);
        logic [1:0]           e;
        logic                 m;
        logic [FP4_MAG_W-1:0] mag;
        e   = raw[FP4_EXP_MSB:FP4_EXP_LSB];
        m   = raw[FP4_MAN_BIT];
        mag = '0;
        case (e)
            2'b00:   mag = m ? FP4_MAG_W'(1)  : FP4_MAG_W'(0);
            2'b01:   mag = m ? FP4_MAG_W'(3)  : FP4_MAG_W'(2);
            2'b10:   mag = m ? FP4_MAG_W'(6)  : FP4_MAG_W'(4);
            default: mag = m ? FP4_MAG_W'(12) : FP4_MAG_W'(8);
        endcase
        return mag;
    endfunction

endpackage

// File: rtl/fp4_to_fixed.sv
// Combinational FP4 -> signed fixed point (LSB = 0.5); negative zero maps to 0.
module fp4_to_fixed
    import fp4_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  fp4_t                    fp_i,
    output logic signed [ACC_W-1:0] fixed_o
);

    logic [FP4_MAG_W-1:0] mag;
    logic [ACC_W-1:0]     mag_ext;

    always_comb begin
        mag     = fp4_to_half_mag(fp_i);
        mag_ext = ACC_W'(mag);
        fixed_o = fp_i.sign ? (-mag_ext) : mag_ext;
    end

endmodule

// File: rtl/fp4_accumulator.sv
// Accumulates VEC_LEN FP4 products into a saturating signed sum with a valid/ready result register.
module fp4_accumulator
    import fp4_pkg::*;
#(
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned ACC_W   = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_data_valid,
    input  fp4_t                                i_product,
    output logic                                o_ready,
    input  logic                                i_clear,
    output logic signed [ACC_W-1:0]             o_sum,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_overflow,
    output logic [$clog2(VEC_LEN)-1:0]          o_count
);

    localparam int unsigned CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
    localparam logic [ACC_W-1:0] SUM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic signed [ACC_W-1:0] term;
    logic [ACC_W:0]          sum_ext;
    logic [ACC_W-1:0]        add_next;
    logic                    add_sat;
    logic                    is_last;
    logic                    accept;

    fp4_to_fixed #(.ACC_W(ACC_W)) u_decode (
        .fp_i    (i_product),
        .fixed_o (term)
    );

    // Sign-extended add; a carry/sign disagreement means the result left the ACC_W range.
    always_comb begin
        sum_ext  = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
        add_sat  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        add_next = add_sat ? (sum_ext[ACC_W] ? SUM_MIN : SUM_MAX) : sum_ext[ACC_W-1:0];
    end

    assign is_last = (cnt_q == LAST_CNT);
    assign o_ready = !i_clear && !(is_last && valid_q && !i_ready);
    assign accept  = i_data_valid && o_ready;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (i_clear) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (accept) begin
            if (is_last) begin
                sum_d   = add_next;
                ovf_d   = sat_q | add_sat;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end else begin
                acc_d = add_next;
                cnt_d = cnt_q + CNT_W'(1);
                sat_d = sat_q | add_sat;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_sum      = sum_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_count    = cnt_q;

endmodule

// File: tb/tb_fp4_accumulator.sv
// Directed vector table plus randomized run, checked against a queue-based reference model.
module tb_fp4_accumulator;

    localparam int VL = 4;
    localparam int AW = 6;
    localparam int CW = $clog2(VL);
    localparam int SMAX = (1 << (AW - 1)) - 1;
    localparam int SMIN = -(1 << (AW - 1));

    logic          clk = 1'b0;
    logic          i_rst, i_data_valid, i_clear, i_ready;
    logic [3:0]    i_product;
    logic          o_ready, o_valid, o_overflow;
    logic [AW-1:0] o_sum;
    logic [CW-1:0] o_count;

    always #5 clk = ~clk;

    fp4_accumulator #(.VEC_LEN(VL), .ACC_W(AW)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_data_valid (i_data_valid),
        .i_product    (i_product),
        .o_ready      (o_ready),
        .i_clear      (i_clear),
        .o_sum        (o_sum),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_overflow   (o_overflow),
        .o_count      (o_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: terms of the open vector, plus the pending result.
    int terms[$];
    bit pend_v;
    int pend_sum;
    bit pend_ovf;

    function automatic int fp4_value(input logic [3:0] p);
        int e, m, v;
        e = int'(p[2:1]);
        m = int'(p[0]);
        v = (e == 0) ? m : ((1 << e) * (2 + m)) / 2;
        return p[3] ? -v : v;
    endfunction

    function automatic bit model_ready(input bit clr, input bit rdy);
        return !clr && !(terms.size() == VL - 1 && pend_v && !rdy);
    endfunction

    task automatic model_update(input bit rst, input bit dv, input logic [3:0] prod,
                                input bit clr, input bit rdy);
        bit acc_ok;
        int s;
        bit ov;
        if (rst) begin
            terms.delete();
            pend_v = 0; pend_sum = 0; pend_ovf = 0;
            return;
        end
        acc_ok = model_ready(clr, rdy) && dv;
        if (pend_v && rdy) pend_v = 0;
        if (clr) begin
            terms.delete();
        end else if (acc_ok) begin
            terms.push_back(fp4_value(prod));
            if (terms.size() == VL) begin
                s = 0; ov = 0;
                foreach (terms[k]) begin
                    s += terms[k];
                    if (s > SMAX) begin s = SMAX; ov = 1; end
                    if (s < SMIN) begin s = SMIN; ov = 1; end
                end
                pend_v = 1; pend_sum = s; pend_ovf = ov;
                terms.delete();
            end
        end
    endtask

    bit sampled_rdy;

    // One clock: drive, check o_ready before the edge, check registers after it.
    task automatic step(input bit rst, input bit dv, input logic [3:0] prod,
                        input bit clr, input bit rdy, input string tag);
        i_rst = rst; i_data_valid = dv; i_product = prod; i_clear = clr; i_ready = rdy;
        #1;
        sampled_rdy = o_ready;
        check({tag, " o_ready/model"}, int'(o_ready), int'(model_ready(clr, rdy)));
        @(posedge clk);
        model_update(rst, dv, prod, clr, rdy);
        #1;
        check({tag, " o_valid/model"}, int'(o_valid), int'(pend_v));
        check({tag, " o_count/model"}, int'(o_count), terms.size());
        check({tag, " o_sum/model"}, int'($signed(o_sum)), pend_sum);
        check({tag, " o_overflow/model"}, int'(o_overflow), int'(pend_ovf));
    endtask

    typedef struct {
        bit         rst, dv;
        logic [3:0] prod;
        bit         clr, rdy;
        bit         e_rdy;
        int         e_cnt;
        bit         e_v;
        bit         chk;
        int         e_sum;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit dv, input logic [3:0] prod, input bit clr,
                       input bit rdy, input bit e_rdy, input int e_cnt, input bit e_v,
                       input bit chk, input int e_sum, input bit e_ovf);
        vec_t v;
        v.rst = rst; v.dv = dv; v.prod = prod; v.clr = clr; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_v = e_v; v.chk = chk;
        v.e_sum = e_sum; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    initial begin
        //   rst dv prod  clr rdy | rdy cnt v chk sum ovf
        add(1, 0, 4'h0, 0, 1,  1, 0, 0, 1,   0, 0);  // reset state
        add(0, 1, 4'h3, 0, 1,  1, 1, 0, 0,   0, 0);  // basic
        add(0, 1, 4'h5, 0, 1,  1, 2, 0, 0,   0, 0);
        add(0, 1, 4'hB, 0, 1,  1, 3, 0, 0,   0, 0);
        add(0, 1, 4'h1, 0, 1,  1, 0, 1, 1,   7, 0);
        add(0, 1, 4'h0, 0, 1,  1, 1, 0, 0,   0, 0);  // zero / subnormal
        add(0, 1, 4'h8, 0, 1,  1, 2, 0, 0,   0, 0);
        add(0, 1, 4'h1, 0, 1,  1, 3, 0, 0,   0, 0);
        add(0, 1, 4'h9, 0, 1,  1, 0, 1, 1,   0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 4'h7, 0, 1, 1, i + 1, 0, 0, 0, 0);
        add(0, 1, 4'h7, 0, 1,  1, 0, 1, 1,  31, 1);  // positive saturation
        for (int i = 0; i < 3; i++) add(0, 1, 4'hF, 0, 1, 1, i + 1, 0, 0, 0, 0);
        add(0, 1, 4'hF, 0, 1,  1, 0, 1, 1, -32, 1);  // negative saturation
        for (int i = 0; i < 3; i++) add(0, 1, 4'h2, 0, 1, 1, i + 1, 0, 0, 0, 0);
        add(0, 1, 4'h2, 0, 1,  1, 0, 1, 1,   8, 0);  // clean after saturation
        add(0, 0, 4'h0, 0, 1,  1, 0, 0, 0,   0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 4'h1, 0, 0, 1, i + 1, 0, 0, 0, 0);
        add(0, 1, 4'h1, 0, 0,  1, 0, 1, 1,   4, 0);  // vector A held
        add(0, 1, 4'h2, 0, 0,  1, 1, 1, 1,   4, 0);
        add(0, 1, 4'h2, 0, 0,  1, 2, 1, 1,   4, 0);
        add(0, 1, 4'h3, 0, 0,  1, 3, 1, 1,   4, 0);
        add(0, 1, 4'h3, 0, 0,  0, 3, 1, 1,   4, 0);  // stalled final element
        add(0, 1, 4'h3, 0, 1,  1, 0, 1, 1,  10, 0);  // swap A -> B back-to-back
        add(0, 0, 4'h0, 0, 1,  1, 0, 0, 0,   0, 0);
        add(0, 1, 4'h7, 0, 1,  1, 1, 0, 0,   0, 0);  // clear
        add(0, 1, 4'h7, 0, 1,  1, 2, 0, 0,   0, 0);
        add(0, 1, 4'h7, 1, 1,  0, 0, 0, 0,   0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 4'h2, 0, 1, 1, i + 1, 0, 0, 0, 0);
        add(0, 1, 4'h2, 0, 1,  1, 0, 1, 1,   8, 0);
        add(0, 0, 4'h0, 1, 0,  0, 0, 1, 1,   8, 0);  // clear keeps pending result
        for (int i = 0; i < 3; i++) add(0, 1, 4'h1, 0, 0, 1, i + 1, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 0,  0, 0, 0, 1,   0, 0);  // reset mid-vector, result pending
        for (int i = 0; i < 3; i++) add(0, 1, 4'h5, 0, 1, 1, i + 1, 0, 0, 0, 0);
        add(0, 1, 4'h5, 0, 1,  1, 0, 1, 1,  24, 0);

        i_rst = 1; i_data_valid = 0; i_product = '0; i_clear = 0; i_ready = 1;
        terms.delete(); pend_v = 0; pend_sum = 0; pend_ovf = 0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[n]) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            step(tbl[n].rst, tbl[n].dv, tbl[n].prod, tbl[n].clr, tbl[n].rdy, tag);
            check({tag, " o_ready"}, int'(sampled_rdy), int'(tbl[n].e_rdy));
            check({tag, " o_count"}, int'(o_count), tbl[n].e_cnt);
            check({tag, " o_valid"}, int'(o_valid), int'(tbl[n].e_v));
            if (tbl[n].chk) begin
                check({tag, " o_sum"}, int'($signed(o_sum)), tbl[n].e_sum);
                check({tag, " o_overflow"}, int'(o_overflow), int'(tbl[n].e_ovf));
            end
        end

        for (int n = 0; n < 3000; n++) begin
            bit rst, dv, clr, rdy;
            logic [3:0] prod;
            rst  = ($urandom_range(0, 299) == 0);
            dv   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            rdy  = ($urandom_range(0, 1) == 1);
            prod = 4'($urandom_range(0, 15));
            step(rst, dv, prod, clr, rdy, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
